// File: rtl/matrix_scroll_ctrl.sv
// Scrolling 8x8 LED matrix controller: 16-row frame buffer, stepped scroll
// offset with IDLE/RUN/PAUSED control, and a free-running row scanner.
module matrix_scroll_ctrl #(
    parameter int unsigned TICK_DIV  = 12500000,
    parameter int unsigned SCAN_BITS = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    output logic       busy,
    output logic [3:0] offset,
    output logic       wrap_pulse,
    output logic [2:0] scanout,
    output logic [7:0] segout
);

    localparam int unsigned TICK_W = 26;
    localparam int unsigned SCAN_W = SCAN_BITS + 3;
    localparam int unsigned ROWS   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_e;

    state_e              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [3:0]          offset_q;
    logic                wrap_q;
    logic                busy_q;
    logic [SCAN_W-1:0]   scan_q;
    logic [7:0]          seg_q;
    logic [7:0]          mem_q [ROWS];
    logic [3:0]          rd_idx_c;

    assign rd_idx_c = offset_q + 4'(scan_q[SCAN_W-1 -: 3]);

    // Control FSM; pause level gates the tick so a released pause resumes counting at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            offset_q <= '0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        tick_q  <= '0;
                    end
                end
                RUN, PAUSED: begin
                    if (stop) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        offset_q <= '0;
                        tick_q   <= '0;
                    end else begin
                        state_q <= pause ? PAUSED : RUN;
                        if (!pause) begin
                            if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                                tick_q   <= '0;
                                offset_q <= dir ? offset_q - 4'd1 : offset_q + 4'd1;
                                wrap_q   <= dir ? (offset_q == 4'd0) : (offset_q == 4'd15);
                            end else begin
                                tick_q <= tick_q + TICK_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Row scanner and display pipeline; blanking on stop avoids one stale frame row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
            seg_q  <= 8'hFF;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
            if (state_q == IDLE || stop) begin
                seg_q <= 8'hFF;
            end else begin
                seg_q <= mem_q[rd_idx_c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy       = busy_q;
    assign offset     = offset_q;
    assign wrap_pulse = wrap_q;
    assign scanout    = scan_q[SCAN_W-1 -: 3];
    assign segout     = seg_q;

endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// Directed self-checking bench for matrix_scroll_ctrl (TICK_DIV=4, SCAN_BITS=1).
module tb_matrix_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, stop, pause, dir;
    logic       busy;
    logic [3:0] offset;
    logic       wrap_pulse;
    logic [2:0] scanout;
    logic [7:0] segout;

    int checks = 0;
    int errors = 0;

    matrix_scroll_ctrl #(.TICK_DIV(4), .SCAN_BITS(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .pause(pause), .dir(dir), .busy(busy),
        .offset(offset), .wrap_pulse(wrap_pulse), .scanout(scanout), .segout(segout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int      wraps;
        int      wrap_at;
        bit      found;
        logic [2:0] prev_scan;

        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_offset", offset, 0);
        chk("rst_segout", segout, 8'hFF);
        chk("rst_scanout", scanout, 0);
        chk("rst_wrap", wrap_pulse, 0);
        reset = 1'b1;
        tick(3);
        chk("idle_hold_busy", busy, 0);

        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'(k);
            tick();
        end
        wr_en = 1'b0;

        // start, step every 4 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_offset", offset, 0);
        tick(3);
        chk("pre_step1", offset, 0);
        tick();
        chk("step1", offset, 1);
        tick(4);
        chk("step2", offset, 2);

        // freeze at offset 2 and look at the row under scanout 3
        pause = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_scan = scanout;
            tick();
            if (prev_scan == 3'd3) begin
                chk("seg_off2_row3", segout, 8'h05);
                found = 1'b1;
            end
        end
        if (!found) chk("seg_scan_timeout", 0, 1);
        chk("pause_hold_off", offset, 2);

        // stop returns to IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_offset", offset, 0);
        chk("stop_seg", segout, 8'hFF);

        // full lap forward: one wrap, on the 16th step
        start = 1'b1;
        tick();
        start = 1'b0;
        wraps = 0; wrap_at = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (wrap_pulse) begin
                wraps++;
                wrap_at = i;
            end
        end
        chk("lap_offset", offset, 0);
        chk("lap_wraps", wraps, 1);
        chk("lap_wrap_at", wrap_at, 64);
        tick();
        chk("wrap_one_cycle", wrap_pulse, 0);

        // reverse: dir changed mid-interval, step time unchanged
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        dir = 1'b1;
        tick();
        chk("dir_mid_offset", offset, 0);
        tick();
        chk("rev_offset", offset, 15);
        chk("rev_wrap", wrap_pulse, 1);
        tick();
        chk("rev_wrap_clear", wrap_pulse, 0);

        // pause with tick=1: 3 counting cycles remain after release
        pause = 1'b1;
        tick(10);
        chk("pause_offset", offset, 15);
        chk("pause_busy", busy, 1);
        pause = 1'b0;
        tick(2);
        chk("resume_pre", offset, 15);
        tick();
        chk("resume_step", offset, 14);
        chk("resume_nowrap", wrap_pulse, 0);

        // start and stop together in RUN
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_offset", offset, 0);
        chk("ss_seg", segout, 8'hFF);

        // reset mid-run at offset 7
        dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(28);
        chk("pre_rst_offset", offset, 7);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_offset", offset, 0);
        chk("mid_rst_seg", segout, 8'hFF);
        chk("mid_rst_scan", scanout, 0);
        chk("mid_rst_wrap", wrap_pulse, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("post_rst_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("buf_cleared", segout, 8'hFF);
        end

        // writes to the displayed rows show within 2 cycles
        pause = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'hA5;
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("write_visible", segout, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scroll_ctrl.md
MATRIX_SCROLL_CTRL -- requirements
Module: matrix_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12500000, clk cycles per scroll step (legal range 2..2^26-1).
REQ-002 The block SHALL have parameter SCAN_BITS, default 13, log2 of the clk cycles spent on each scanned row.
REQ-003 The block SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1, frame-buffer write strobe.
REQ-006 The block SHALL have port wr_addr, input, 4, frame-buffer row index 0..15.
REQ-007 The block SHALL have port wr_data, input, 8, row pattern, active-low pixels.
REQ-008 The block SHALL have port start, input, 1, level; begin scrolling from IDLE.
REQ-009 The block SHALL have port stop, input, 1, level; return to IDLE.
REQ-010 The block SHALL have port pause, input, 1, level; freeze the scroll position while high.
REQ-011 The block SHALL have port dir, input, 1, scroll direction: 0 = offset increments, 1 = offset decrements.
REQ-012 The block SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-013 The block SHALL have port offset, output, 4, current first-displayed buffer row.
REQ-014 The block SHALL have port wrap_pulse, output, 1, one-cycle pulse on offset wrap.
REQ-015 The block SHALL have port scanout, output, 3, active row select 0..7.
REQ-016 The block SHALL have port segout, output, 8, pattern for the active row.

Function
REQ-017 The block SHALL hold a 16x8 frame buffer, written when wr_en=1 at the clk edge (buf[wr_addr] <= wr_data) in any state, including the same cycle as a scroll step.
REQ-018 The block SHALL implement FSM states IDLE, RUN and PAUSED.
REQ-019 The FSM SHALL make these transitions:
  - IDLE->RUN on start=1
  - RUN->PAUSED on pause=1
  - PAUSED->RUN on pause=0
  - RUN/PAUSED->IDLE on stop=1
  - stop has priority over start and pause; start is ignored outside IDLE.
REQ-020 On entry to IDLE, the block SHALL clear offset to 0 and the tick counter to 0; on IDLE->RUN, the tick counter SHALL start at 0.
REQ-021 In RUN, the tick counter SHALL increment each cycle; at value TICK_DIV-1 it SHALL return to 0 and offset SHALL step by +1 (dir=0) or -1 (dir=1), modulo 16.
REQ-022 In PAUSED, the block SHALL hold both the tick counter and offset.
REQ-023 The block SHALL sample dir only at the cycle of each step; a dir change mid-interval SHALL NOT reset the tick counter.
REQ-024 wrap_pulse SHALL be 1 for exactly the cycle after the step edge that moves offset 15->0 (dir=0) or 0->15 (dir=1), and 0 otherwise.
REQ-025 A free-running scan counter of SCAN_BITS+3 bits SHALL increment every cycle in all states, and scanout SHALL equal its top 3 bits (registered).
REQ-026 segout SHALL be registered, with one cycle of latency from scanout/offset/buffer: buf[(offset+scanout) mod 16] in RUN or PAUSED, and 8'hFF (blank) in IDLE.
REQ-027 A buffer write to the row currently displayed SHALL appear on segout no later than 2 cycles after the write edge.
REQ-028 busy SHALL be registered from the FSM state, going high the cycle after start is accepted.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force: state IDLE, offset 0, tick counter 0, scan counter 0, scanout 0, segout 8'hFF, busy 0, wrap_pulse 0, and all 16 buffer rows 8'hFF.
REQ-030 Reset asserted mid-RUN SHALL abandon the scroll immediately, with no wrap_pulse generated.
REQ-031 After reset release, the block SHALL stay in IDLE until start=1 is seen at a clk edge.

Verification (TICK_DIV=4, SCAN_BITS=1)
REQ-032 The bench SHALL cover: reset, then write buf[k]=k for k=0..15, then start -> busy=1 next cycle; offset=1 after 4 cycles, 2 after 8; segout when scanout=3 with offset=2 equals 8'h05.
REQ-033 The bench SHALL cover: dir=0 run for 64 cycles -> offset back to 0, exactly one wrap_pulse in the step that moves 15->0.
REQ-034 The bench SHALL cover: dir=1 from offset 0 -> first step gives offset=15 with wrap_pulse=1.
REQ-035 The bench SHALL cover: pause=1 for 10 cycles mid-interval -> offset and tick counter unchanged; after release, the next step lands exactly the remaining tick count later.
REQ-036 The bench SHALL cover: start=1 and stop=1 in the same cycle while in RUN -> IDLE, offset=0, segout=8'hFF within 1 cycle.
REQ-037 The bench SHALL cover: reset pulse during RUN at offset=7 -> all outputs at reset values immediately; buffer reads back 8'hFF after restart.
